// File: rtl/sim_mon_pkg.sv
// Shared types and default mailbox addresses for the simulation exit monitor.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone,
    StTout
  } mon_state_e;

  localparam logic [31:0] PrintAddrDef = 32'h1000_0000;
  localparam logic [31:0] ExitAddrDef  = 32'h1000_0004;
  localparam logic [31:0] HbeatAddrDef = 32'h1000_0008;

endpackage

// File: rtl/sim_mon_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push while full is accepted only with a pop.
module sim_mon_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned DP = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DW-1:0]         data_i,
  input  logic                  pop_i,
  output logic [DW-1:0]         data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DP):0]   count_o
);

  localparam int unsigned AddrW = $clog2(DP);

  logic [DW-1:0]  mem_q [DP];
  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic           push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sim_exit_monitor.sv
// Snoops ICB write commands for print/exit/heartbeat mailboxes and raises run-end flags.
module sim_exit_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned   NCH         = 1,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   FIFO_DP     = 16,
  parameter int unsigned   TIMEOUT_CYC = 2000000,
  parameter logic [AW-1:0] PRINT_ADDR  = AW'(PrintAddrDef),
  parameter logic [AW-1:0] EXIT_ADDR   = AW'(ExitAddrDef),
  parameter logic [AW-1:0] HBEAT_ADDR  = AW'(HbeatAddrDef)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    icb_cmd_valid_i,
  input  logic [NCH-1:0]    icb_cmd_ready_i,
  input  logic [NCH-1:0]    icb_cmd_read_i,
  input  logic [NCH*AW-1:0] icb_cmd_addr_i,
  input  logic [NCH*32-1:0] icb_cmd_wdata_i,
  output logic              char_valid_o,
  output logic [7:0]        char_data_o,
  input  logic              char_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [31:0]       exit_code_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYC);
  localparam int unsigned    CntW   = $clog2(FIFO_DP) + 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  mon_state_e state_q, state_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [31:0]     exit_q, exit_d;
  logic [15:0]     drop_q, drop_d;
  logic            done_q, pass_q, fail_q, tout_q;

  logic [NCH-1:0]  print_hit, exit_hit, hbeat_hit;
  logic [AW-1:0]   addr;
  logic            fire;
  logic [7:0]      push_data;
  logic [31:0]     exit_data;
  logic [2:0]      n_print;
  logic            any_print, any_exit, reload;

  logic            fifo_full, fifo_empty, fifo_pop, full_drop;
  logic [CntW-1:0] fifo_cnt;
  logic [2:0]      drop_inc;
  logic [16:0]     drop_sum;

  // Descending scan so the lowest-index channel's data is the one left standing.
  always_comb begin
    print_hit = '0;
    exit_hit  = '0;
    hbeat_hit = '0;
    addr      = '0;
    fire      = 1'b0;
    push_data = '0;
    exit_data = '0;
    n_print   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      fire         = icb_cmd_valid_i[i] & icb_cmd_ready_i[i] & ~icb_cmd_read_i[i];
      addr         = icb_cmd_addr_i[i*AW +: AW];
      print_hit[i] = fire && (addr == PRINT_ADDR);
      exit_hit[i]  = fire && (addr == EXIT_ADDR);
      hbeat_hit[i] = fire && (addr == HBEAT_ADDR);
      n_print      = n_print + {2'b00, print_hit[i]};
      if (print_hit[i]) push_data = icb_cmd_wdata_i[i*32 +: 8];
      if (exit_hit[i])  exit_data = icb_cmd_wdata_i[i*32 +: 32];
    end
  end

  assign any_print = |print_hit;
  assign any_exit  = |exit_hit;
  assign reload    = any_print | (|hbeat_hit);

  assign fifo_pop  = !fifo_empty && char_ready_i;
  assign full_drop = any_print && fifo_full && !fifo_pop;
  assign drop_inc  = any_print ? (n_print - 3'd1 + {2'b00, full_drop}) : 3'd0;
  assign drop_sum  = {1'b0, drop_q} + {14'd0, drop_inc};
  assign drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  sim_mon_fifo #(
    .DW (8),
    .DP (FIFO_DP)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (any_print),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (char_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    exit_d  = exit_q;
    unique case (state_q)
      StRun: begin
        wdog_d = reload ? '0 : wdog_q + WdW'(1);
        if (any_exit) begin
          exit_d  = exit_data;
          state_d = StDrain;
        end else if (wdog_q == WdLast && !reload) begin
          state_d = StTout;
        end
      end
      StDrain: begin
        // Wait out any byte being pushed this cycle before declaring the run done.
        if (fifo_cnt == '0 && !any_print) state_d = StDone;
      end
      StDone:  state_d = StDone;
      StTout:  state_d = StTout;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wdog_q  <= '0;
      exit_q  <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      exit_q  <= exit_d;
      drop_q  <= drop_d;
      done_q  <= (state_q == StDone) || (state_q == StTout);
      pass_q  <= (state_q == StDone) && (exit_q == 32'd0);
      fail_q  <= (state_q == StDone) && (exit_q != 32'd0);
      tout_q  <= (state_q == StTout);
    end
  end

  assign char_valid_o = !fifo_empty;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = tout_q;
  assign exit_code_o  = exit_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Scenario bench for sim_exit_monitor: two channels, 4-deep FIFO, 100-cycle watchdog.
module tb_sim_exit_monitor;

  localparam logic [31:0] PA = 32'h1000_0000;
  localparam logic [31:0] EA = 32'h1000_0004;
  localparam logic [31:0] HA = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0, ready = '0, rd = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic        char_valid, char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        done, pass, fail, timeout;
  logic [31:0] exit_code;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  sim_exit_monitor #(
    .NCH         (2),
    .AW          (32),
    .FIFO_DP     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .icb_cmd_valid_i (valid),
    .icb_cmd_ready_i (ready),
    .icb_cmd_read_i  (rd),
    .icb_cmd_addr_i  (addr),
    .icb_cmd_wdata_i (wdata),
    .char_valid_o    (char_valid),
    .char_data_o     (char_data),
    .char_ready_i    (char_ready),
    .done_o          (done),
    .pass_o          (pass),
    .fail_o          (fail),
    .timeout_o       (timeout),
    .exit_code_o     (exit_code),
    .drop_cnt_o      (drop_cnt)
  );

  // Sink scoreboard: each accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL char_unexpected: got %02h, queue empty", char_data);
      end else begin
        if (char_data !== sb[0]) begin
          n_fail = n_fail + 1;
          $display("FAIL char_order: got %02h want %02h", char_data, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  // One-cycle command on both channels; starts and ends just after a rising edge.
  task automatic cmd(input logic [1:0] v, input logic [1:0] r, input logic [1:0] rdn,
                     input logic [31:0] a0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [31:0] d1);
    valid = v; ready = r; rd = rdn; addr = {a1, a0}; wdata = {d1, d0};
    @(posedge clk); #1;
    valid = '0; ready = '0; rd = '0;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    cmd(2'b01, 2'b01, 2'b00, a, d, 32'd0, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; char_ready = 1'b0; valid = '0; ready = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if ({done, pass, fail, timeout, char_valid} !== 5'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_flags: got %05b want 00000", {done, pass, fail, timeout, char_valid});
    end
    n_checks = n_checks + 1;
    if (exit_code !== 32'd0 || drop_cnt !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_values: exit_code %0h drop %0d want 0 0", exit_code, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_hello();
    int i;
    char_ready = 1'b1;
    sb.push_back(8'h48); wr0(PA, 32'h48);
    cmd(2'b01, 2'b00, 2'b00, PA, 32'h58, 32'd0, 32'd0);  // not ready: must not print
    sb.push_back(8'h69); wr0(PA, 32'h69);
    sb.push_back(8'h0A); wr0(PA, 32'h0A);
    wr0(EA, 32'd0);
    for (i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_checks = n_checks + 1;
    if (done !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL hello_done: got %0b want 1 within 30 cycles", done);
    end
    n_checks = n_checks + 1;
    if ({pass, fail, timeout} !== 3'b100 || exit_code !== 32'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL hello_result: pass/fail/tout %03b code %0h want 100 0",
               {pass, fail, timeout}, exit_code);
    end
    n_checks = n_checks + 1;
    if (sb.size() != 0 || drop_cnt !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL hello_drain: %0d bytes pending, drop %0d want 0 0", sb.size(), drop_cnt);
    end
  endtask

  task automatic test_overflow();
    int i;
    char_ready = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      if (b <= 4) sb.push_back(8'(b));
      wr0(PA, 32'(b));
    end
    n_checks = n_checks + 1;
    if (drop_cnt !== 16'd2 || char_valid !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL ovf_drop: drop %0d valid %0b want 2 1", drop_cnt, char_valid);
    end
    // Push into a full FIFO while popping: accepted, no drop.
    char_ready = 1'b1;
    sb.push_back(8'h07);
    wr0(PA, 32'h07);
    char_ready = 1'b0;
    n_checks = n_checks + 1;
    if (drop_cnt !== 16'd2) begin
      n_fail = n_fail + 1;
      $display("FAIL full_pushpop: drop %0d want 2", drop_cnt);
    end
    wr0(EA, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (done !== 1'b0 || exit_code !== 32'd3) begin
      n_fail = n_fail + 1;
      $display("FAIL drain_hold: done %0b code %0h want 0 3", done, exit_code);
    end
    char_ready = 1'b1;
    for (i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_checks = n_checks + 1;
    if (done !== 1'b1 || {pass, fail, timeout} !== 3'b010 || exit_code !== 32'd3) begin
      n_fail = n_fail + 1;
      $display("FAIL ovf_result: done %0b pass/fail/tout %03b code %0h want 1 010 3",
               done, {pass, fail, timeout}, exit_code);
    end
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL ovf_drain: %0d bytes pending want 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 101; k++) begin
      @(posedge clk); #1;
      if (k == 100) begin
        n_checks = n_checks + 1;
        if (timeout !== 1'b0 || done !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL tout_early: tout %0b done %0b at cycle 100 want 0 0", timeout, done);
        end
      end
    end
    n_checks = n_checks + 1;
    if ({done, pass, fail, timeout} !== 4'b1001) begin
      n_fail = n_fail + 1;
      $display("FAIL tout_flags: done/pass/fail/tout %04b at cycle 101 want 1001",
               {done, pass, fail, timeout});
    end
  endtask

  task automatic test_heartbeat();
    for (int c = 0; c < 1000; c++) begin
      if (c % 50 == 0) wr0(HA, 32'd0);
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks = n_checks + 1;
    if (timeout !== 1'b0 || done !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL hbeat: tout %0b done %0b want 0 0", timeout, done);
    end
  endtask

  task automatic test_dual_channel();
    int i;
    char_ready = 1'b1;
    sb.push_back(8'h41);
    cmd(2'b11, 2'b11, 2'b00, PA, 32'h41, PA, 32'h42);
    repeat (3) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (drop_cnt !== 16'd1 || sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL dual_print: drop %0d pending %0d want 1 0", drop_cnt, sb.size());
    end
    cmd(2'b11, 2'b11, 2'b00, EA, 32'd0, EA, 32'd5);
    for (i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_checks = n_checks + 1;
    if (done !== 1'b1 || pass !== 1'b1 || exit_code !== 32'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL dual_exit: done %0b pass %0b code %0h want 1 1 0", done, pass, exit_code);
    end
  endtask

  task automatic test_exit_vs_expiry();
    int i;
    repeat (9) @(posedge clk);
    #1;
    cmd(2'b01, 2'b01, 2'b01, EA, 32'd7, 32'd0, 32'd0);  // read: ignored
    repeat (3) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (exit_code !== 32'd0 || done !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL exit_read: code %0h done %0b want 0 0", exit_code, done);
    end
    repeat (86) @(posedge clk);
    #1;
    wr0(EA, 32'd0);  // sampled in the cycle the watchdog reaches its last count
    for (i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_checks = n_checks + 1;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL exit_wins: done %0b pass %0b tout %0b want 1 1 0", done, pass, timeout);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks = n_checks + 1;
    if ({done, pass, fail, timeout, char_valid} !== 5'b0 ||
        exit_code !== 32'd0 || drop_cnt !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL midrun_reset: flags %05b code %0h drop %0d want 0 0 0",
               {done, pass, fail, timeout, char_valid}, exit_code, drop_cnt);
    end
    sb.delete();
    test_hello();
  endtask

  initial begin
    test_reset();
    apply_reset(); test_hello();
    apply_reset(); test_overflow();
    apply_reset(); test_timeout();
    apply_reset(); test_heartbeat();
    apply_reset(); test_dual_channel();
    apply_reset(); test_exit_vs_expiry();
    apply_reset(); test_hello(); test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
